sim_vga_tx: RTL

Synthesizable VGA transmitter producing RGB222 pixel data plus HSYNC/VSYNC, the source end of the SimIO VGA sink interface. Drives r/g/b/hs/vs directly into simio_vga so we can self-test the VGA viewer without an external design. Contains parameterizable timing counters and a small built-in test-pattern generator. Pattern select is runtime-switchable and is applied only on frame boundaries.

---
 rtl/sim_vga_tx_pkg.sv | 42 ++++
 rtl/sim_vga_tx_timing.sv | 74 +++++++
 rtl/sim_vga_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sim_vga_tx_pkg.sv
// Shared types and constants for the SimIO VGA test-pattern transmitter.
package sim_vga_tx_pkg;

  // Default 640x480@60 timing
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_WHITE    = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  localparam rgb222_t RGB_BLACK = 6'b00_00_00;
  localparam rgb222_t RGB_WHITE = 6'b11_11_11;

  // Colour bars, left to right, packed as {r, g, b}
  localparam logic [5:0] BAR_COLORS [8] = '{
    6'b11_11_11,  // white
    6'b11_11_00,  // yellow
    6'b00_11_11,  // cyan
    6'b00_11_00,  // green
    6'b11_00_11,  // magenta
    6'b11_00_00,  // red
    6'b00_00_11,  // blue
    6'b00_00_00   // black
  };

endpackage

// File: rtl/sim_vga_tx_timing.sv
// Horizontal/vertical raster counters and raw (unregistered) sync, enable and position flags.
module sim_vga_tx_timing
  import sim_vga_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL),
  localparam int unsigned XW      = $clog2(H_ACTIVE),
  localparam int unsigned YW      = $clog2(V_ACTIVE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          de_o,
  output logic          hs_act_o,
  output logic          vs_act_o,
  output logic          frame_start_o,
  output logic          frame_end_o
);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;

  // Next-state: h wraps every line, v advances only when h wraps
  always_comb begin
    h_last  = (h_cnt_q == HW'(H_TOTAL - 1));
    v_last  = (v_cnt_q == VW'(V_TOTAL - 1));
    h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Raw region decode from the current counter values
  always_comb begin
    h_cnt_o       = h_cnt_q;
    v_cnt_o       = v_cnt_q;
    x_o           = h_cnt_q[XW-1:0];
    y_o           = v_cnt_q[YW-1:0];
    de_o          = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    hs_act_o      = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                    (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_act_o      = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                    (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
    frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_end_o   = h_last && v_last;
  end

endmodule

// File: rtl/sim_vga_tx.sv
// VGA test-pattern transmitter (RGB222 + HSYNC/VSYNC) feeding the SimIO VGA sink.
// Optional build macro SIMIO_VGA_TX_FRAME_CNT_EN adds frame_cnt_o and a scrolling gradient.
module sim_vga_tx
  import sim_vga_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP),
  localparam int unsigned XW = $clog2(H_ACTIVE),
  localparam int unsigned YW = $clog2(V_ACTIVE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    pattern_sel_i,
  output logic [1:0]    r_o,
  output logic [1:0]    g_o,
  output logic [1:0]    b_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
`ifdef SIMIO_VGA_TX_FRAME_CNT_EN
  output logic [15:0]   frame_cnt_o,
`endif
  output logic          frame_start_o
);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [XW-1:0] x_raw;
  logic [YW-1:0] y_raw;
  logic          de_raw, hs_act, vs_act, fs_raw, frame_end;

  sim_vga_tx_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .x_o           (x_raw),
    .y_o           (y_raw),
    .de_o          (de_raw),
    .hs_act_o      (hs_act),
    .vs_act_o      (vs_act),
    .frame_start_o (fs_raw),
    .frame_end_o   (frame_end)
  );

  pattern_e pat_q;

  // Pattern request is only taken on the last pixel of a frame, so frames never tear
  always_ff @(posedge clk_i) begin
    if (rst_i || frame_end) begin
      pat_q <= pattern_e'(pattern_sel_i);
    end
  end

`ifdef SIMIO_VGA_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame index at the counter stage, stepped when the raster wraps to (0,0)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end
`endif

  logic [9:0] px, py, gx;
  logic [2:0] bar_idx;
  rgb222_t    pix;
  logic       unused_bits;

  // Pixel colour from the raster position; bar index built from comparators
  always_comb begin
    px = 10'(h_cnt);
    py = 10'(v_cnt);
    gx = px;
`ifdef SIMIO_VGA_TX_FRAME_CNT_EN
    gx = px + frame_cnt_q[9:0];
`endif
    bar_idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h_cnt >= HW'(k * (H_ACTIVE / 8))) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
    pix = RGB_BLACK;
    unique case (pat_q)
      PAT_BARS:     pix = rgb222_t'(BAR_COLORS[bar_idx]);
      PAT_CHECKER:  pix = (px[5] ^ py[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_GRADIENT: begin
        pix.r = gx[7:6];
        pix.g = py[7:6];
        pix.b = gx[9:8];
      end
      PAT_WHITE:    pix = RGB_WHITE;
      default:      pix = RGB_BLACK;
    endcase
  end

  assign unused_bits = ^{py[9:8], py[4:0], gx[5:0]};

  rgb222_t rgb_q;

  // Output stage: one cycle behind the counters, all outputs aligned
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q         <= RGB_BLACK;
      hs_o          <= ~HS_POL;
      vs_o          <= ~VS_POL;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      frame_start_o <= 1'b0;
    end else begin
      rgb_q         <= de_raw ? pix : RGB_BLACK;
      hs_o          <= hs_act ? HS_POL : ~HS_POL;
      vs_o          <= vs_act ? VS_POL : ~VS_POL;
      de_o          <= de_raw;
      x_o           <= de_raw ? x_raw : '0;
      y_o           <= de_raw ? y_raw : '0;
      frame_start_o <= fs_raw;
    end
  end

`ifdef SIMIO_VGA_TX_FRAME_CNT_EN
  // Frame count registered alongside the pixel it belongs to
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_o <= '0;
    end else begin
      frame_cnt_o <= frame_cnt_q;
    end
  end
`endif

  assign r_o = rgb_q.r;
  assign g_o = rgb_q.g;
  assign b_o = rgb_q.b;

endmodule
